tdm_demux4: RTL and testbench
=============================

Name: tdm_demux4

Overview:
- Receive end of a 4-channel time-division link. The transmit end uses a 4:1 mux with a rotating 2-bit select to serialise four WIDTH-bit channels onto one bus, and marks slot 0 with sync.
- This block tracks the slot position, rebuilds the four channel words, and presents each complete frame atomically with a one-cycle frame_valid pulse.
- Sits directly after the link, ahead of per-channel consumers.

Parameters:
WIDTH, 4, data width of each channel word and of din
CNT_W, 8, width of the completed-frame counter

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
din  input  WIDTH  serial data beat for the current slot
in_valid  input  1  din/sync qualify this cycle; low = stall, all state holds
sync  input  1  high on the slot-0 beat of each frame
y0  output  WIDTH  channel 0 word of last complete frame
y1  output  WIDTH  channel 1 word of last complete frame
y2  output  WIDTH  channel 2 word of last complete frame
y3  output  WIDTH  channel 3 word of last complete frame
frame_valid  output  1  one-cycle pulse: y0..y3 just updated
locked  output  1  1 = slot alignment held (LOCKED state)
slot  output  2  slot index expected for the next valid beat
sync_err  output  1  one-cycle pulse on alignment violation
frame_cnt  output  CNT_W  count of completed frames, wraps mod 2^CNT_W

Behaviour:
- Reset (sampled at a rising edge with reset=1):
  - y0..y3 = 0, shadow regs = 0, frame_valid = 0, sync_err = 0.
  - slot = 0, locked = 0, state = HUNT, frame_cnt = 0.
  - Reset overrides every other input, including mid-frame; any partial frame is discarded.
- All outputs are registered. frame_valid and sync_err are 0 in any cycle not explicitly pulsed below.
- in_valid = 0: no state, slot, shadow or output change; pulses deassert.
- State HUNT (locked = 0):
  - Valid beat with sync = 0: discarded.
  - Valid beat with sync = 1: din -> shadow0, slot <= 1, go LOCKED.
- State LOCKED (locked = 1), valid beat:
  - slot = 0, sync = 1: din -> shadow0, slot <= 1.
  - slot = 0, sync = 0: missing sync. Beat discarded, sync_err pulses, slot <= 0, go HUNT.
  - slot in 1..2, sync = 0: din -> shadow[slot], slot <= slot + 1.
  - slot = 3, sync = 0 (frame completes): on that edge
    - y0 <= shadow0, y1 <= shadow1, y2 <= shadow2, y3 <= din;
    - frame_valid <= 1, frame_cnt <= frame_cnt + 1 (wraps);
    - slot <= 0.
  - slot in 1..3, sync = 1 (early sync): partial frame discarded, no frame_valid, sync_err pulses. The beat is taken as a new slot 0: din -> shadow0, slot <= 1. Stay LOCKED.
- Latency: y0..y3 and frame_valid change on the same edge that samples the slot-3 beat.
- Outputs hold between frames. A frame with stall gaps (in_valid low between beats) assembles identically to a back-to-back frame.
- Back-to-back frames: the slot-0 beat of the next frame may arrive the cycle after slot 3. frame_valid then pulses once per frame, with no merging.
- frame_cnt wraps 2^CNT_W-1 -> 0 without any flag.

Test Plan:
- Reset, then beats 1(sync), 2, 2, 3 on consecutive cycles -> on the 4th beat's edge: y0=1, y1=2, y2=2, y3=3, frame_valid=1 for exactly one cycle, frame_cnt=1, slot=0, locked=1.
- Same frame with in_valid low for 2 cycles between every beat -> identical y values; one frame_valid pulse; slot holds during the gaps.
- Beats 5, 6 with no sync after reset, then 7(sync), 8, 9, 10 -> the first two are ignored (locked=0); then y0..y3 = 7, 8, 9, 10 and frame_valid pulses.
- Locked, beats 1(sync), 2, then 4(sync), 5, 6, 7 -> sync_err pulses at the second sync; no frame_valid for the 1, 2 partial frame; then y = 4, 5, 6, 7 with frame_valid.
- Locked, slot = 0, beat 9 with sync = 0 -> sync_err pulses, locked=0, y unchanged; next sync beat relocks.
- Reset asserted after two beats of a frame, then a full frame A(sync), B, C, D -> outputs 0 through reset; frame_cnt=1 and y = A..D after the frame; 256 frames with CNT_W=8 -> frame_cnt wraps to 0.

Source files
------------

// File: rtl/tdm_demux4.sv
// Receive side of a 4-slot TDM link: tracks slot alignment from sync, rebuilds
// the four channel words and publishes each complete frame atomically.
module tdm_demux4 #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             in_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic             frame_valid,
  output logic             locked,
  output logic [1:0]       slot,
  output logic             sync_err,
  output logic [CNT_W-1:0] frame_cnt
);

  typedef enum logic [0:0] {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t             state_r, state_s;
  logic [1:0]         slot_r, slot_s;
  logic [WIDTH-1:0]   sh0_r, sh1_r, sh2_r;
  logic [WIDTH-1:0]   sh0_s, sh1_s, sh2_s;
  logic [WIDTH-1:0]   y0_r, y1_r, y2_r, y3_r;
  logic [WIDTH-1:0]   y0_s, y1_s, y2_s, y3_s;
  logic               fv_r, fv_s;
  logic               err_r, err_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic               frame_done_s;
  logic               sync_viol_s;

  // Slot 3 carries the last channel word straight from din; the other three come from shadows.
  assign frame_done_s = in_valid && (state_r == LOCKED) && !sync && (slot_r == 2'd3);
  assign sync_viol_s  = in_valid && (state_r == LOCKED) &&
                        ((!sync && (slot_r == 2'd0)) || (sync && (slot_r != 2'd0)));

  // State, shadow and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= HUNT;
      slot_r  <= 2'd0;
      sh0_r   <= {WIDTH{1'b0}};
      sh1_r   <= {WIDTH{1'b0}};
      sh2_r   <= {WIDTH{1'b0}};
      y0_r    <= {WIDTH{1'b0}};
      y1_r    <= {WIDTH{1'b0}};
      y2_r    <= {WIDTH{1'b0}};
      y3_r    <= {WIDTH{1'b0}};
      fv_r    <= 1'b0;
      err_r   <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_s;
      slot_r  <= slot_s;
      sh0_r   <= sh0_s;
      sh1_r   <= sh1_s;
      sh2_r   <= sh2_s;
      y0_r    <= y0_s;
      y1_r    <= y1_s;
      y2_r    <= y2_s;
      y3_r    <= y3_s;
      fv_r    <= fv_s;
      err_r   <= err_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next alignment state, slot pointer and shadow capture
  always_comb begin
    state_s = state_r;
    slot_s  = slot_r;
    sh0_s   = sh0_r;
    sh1_s   = sh1_r;
    sh2_s   = sh2_r;
    if (in_valid) begin
      case (state_r)
        HUNT: begin
          if (sync) begin
            sh0_s   = din;
            slot_s  = 2'd1;
            state_s = LOCKED;
          end else begin
            slot_s  = 2'd0;
          end
        end
        LOCKED: begin
          if (sync) begin
            // Sync always starts a fresh frame, even when it arrives early.
            sh0_s  = din;
            slot_s = 2'd1;
          end else begin
            case (slot_r)
              2'd0: begin
                slot_s  = 2'd0;
                state_s = HUNT;
              end
              2'd1: begin
                sh1_s  = din;
                slot_s = 2'd2;
              end
              2'd2: begin
                sh2_s  = din;
                slot_s = 2'd3;
              end
              2'd3: begin
                slot_s = 2'd0;
              end
              default: begin
                slot_s  = 2'd0;
                state_s = HUNT;
              end
            endcase
          end
        end
        default: begin
          state_s = HUNT;
          slot_s  = 2'd0;
        end
      endcase
    end else begin
      state_s = state_r;
      slot_s  = slot_r;
    end
  end

  // Frame publication, pulses and frame counter
  always_comb begin
    y0_s  = y0_r;
    y1_s  = y1_r;
    y2_s  = y2_r;
    y3_s  = y3_r;
    fv_s  = 1'b0;
    cnt_s = cnt_r;
    if (frame_done_s) begin
      y0_s  = sh0_r;
      y1_s  = sh1_r;
      y2_s  = sh2_r;
      y3_s  = din;
      fv_s  = 1'b1;
      cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      fv_s  = 1'b0;
    end
    if (sync_viol_s) begin
      err_s = 1'b1;
    end else begin
      err_s = 1'b0;
    end
  end

  assign y0          = y0_r;
  assign y1          = y1_r;
  assign y2          = y2_r;
  assign y3          = y3_r;
  assign frame_valid = fv_r;
  assign sync_err    = err_r;
  assign frame_cnt   = cnt_r;
  assign locked      = (state_r == LOCKED);
  assign slot        = slot_r;

endmodule

// File: tb/tb_tdm_demux4.sv
// Scoreboard bench for tdm_demux4: stimulus queues expected frames, a monitor
// pops them on every frame_valid and tallies sync_err pulses.
module tb_tdm_demux4;

  logic       clk;
  logic       reset;
  logic [3:0] din;
  logic       in_valid;
  logic       sync;
  logic [3:0] y0, y1, y2, y3;
  logic       frame_valid;
  logic       locked;
  logic [1:0] slot;
  logic       sync_err;
  logic [7:0] frame_cnt;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] c;
    logic [3:0] d;
    logic [7:0] cnt;
  } frame_t;

  frame_t     exp_q[$];
  logic [7:0] exp_cnt;
  int         nvec;
  int         nmis;
  int         err_seen;

  tdm_demux4 #(.WIDTH(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .din(din), .in_valid(in_valid), .sync(sync),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3), .frame_valid(frame_valid),
    .locked(locked), .slot(slot), .sync_err(sync_err), .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec = nvec + 1;
    if (act !== exp) begin
      nmis = nmis + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every frame_valid cycle must match the oldest queued frame.
  initial begin
    forever begin
      @(negedge clk);
      if (sync_err === 1'b1) err_seen = err_seen + 1;
      if (frame_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          nvec = nvec + 1;
          nmis = nmis + 1;
          $display("FAIL unexpected_frame: got y=%h %h %h %h expected no frame_valid", y0, y1, y2, y3);
        end else begin
          frame_t e;
          e = exp_q.pop_front();
          chk("frame_y0", 32'(y0), 32'(e.a));
          chk("frame_y1", 32'(y1), 32'(e.b));
          chk("frame_y2", 32'(y2), 32'(e.c));
          chk("frame_y3", 32'(y3), 32'(e.d));
          chk("frame_cnt", 32'(frame_cnt), 32'(e.cnt));
        end
      end
    end
  end

  task automatic beat(input logic [3:0] d, input logic s);
    din = d;
    sync = s;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    sync = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_cnt = 8'd0;
  endtask

  task automatic expect_frame(input logic [3:0] a, input logic [3:0] b,
                              input logic [3:0] c, input logic [3:0] d);
    frame_t f;
    exp_cnt = exp_cnt + 8'd1;
    f.a = a; f.b = b; f.c = c; f.d = d; f.cnt = exp_cnt;
    exp_q.push_back(f);
  endtask

  task automatic send_frame(input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] c, input logic [3:0] d, input int gap);
    expect_frame(a, b, c, d);
    beat(a, 1'b1); idle(gap);
    beat(b, 1'b0); idle(gap);
    beat(c, 1'b0); idle(gap);
    beat(d, 1'b0);
  endtask

  initial begin
    nvec = 0; nmis = 0; err_seen = 0; exp_cnt = 8'd0;
    reset = 1'b1; in_valid = 1'b0; sync = 1'b0; din = 4'd0;
    idle(2);
    do_reset();
    chk("rst_y0", 32'(y0), 32'd0);
    chk("rst_y3", 32'(y3), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_slot", 32'(slot), 32'd0);
    chk("rst_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_fv", 32'(frame_valid), 32'd0);

    // Back-to-back frame
    send_frame(4'd1, 4'd2, 4'd2, 4'd3, 0);
    chk("b2b_slot", 32'(slot), 32'd0);
    chk("b2b_locked", 32'(locked), 32'd1);
    idle(1);

    // Same frame with two stall cycles between beats
    expect_frame(4'd1, 4'd2, 4'd2, 4'd3);
    beat(4'd1, 1'b1); idle(2);
    chk("gap_slot_hold", 32'(slot), 32'd1);
    beat(4'd2, 1'b0); idle(2);
    chk("gap_slot_hold2", 32'(slot), 32'd2);
    beat(4'd2, 1'b0); idle(2);
    beat(4'd3, 1'b0); idle(2);
    chk("gap_y_hold", 32'(y3), 32'd3);

    // Hunting: unsynced beats are discarded
    do_reset();
    beat(4'd5, 1'b0);
    beat(4'd6, 1'b0);
    chk("hunt_locked", 32'(locked), 32'd0);
    chk("hunt_slot", 32'(slot), 32'd0);
    send_frame(4'd7, 4'd8, 4'd9, 4'd10, 0);
    chk("hunt_err", 32'(err_seen), 32'd0);

    // Early sync abandons the partial frame
    beat(4'd1, 1'b1);
    beat(4'd2, 1'b0);
    send_frame(4'd4, 4'd5, 4'd6, 4'd7, 0);
    idle(1);
    chk("early_sync_err", 32'(err_seen), 32'd1);

    // Missing sync at slot 0 drops lock
    beat(4'd9, 1'b0);
    idle(1);
    chk("miss_err", 32'(err_seen), 32'd2);
    chk("miss_locked", 32'(locked), 32'd0);
    chk("miss_y0", 32'(y0), 32'd4);
    chk("miss_y3", 32'(y3), 32'd7);
    expect_frame(4'd1, 4'd3, 4'd5, 4'd7);
    beat(4'd1, 1'b1);
    chk("relock", 32'(locked), 32'd1);
    beat(4'd3, 1'b0);
    beat(4'd5, 1'b0);
    beat(4'd7, 1'b0);

    // Reset mid-frame, then counter wrap over 256 frames
    beat(4'd11, 1'b1);
    beat(4'd12, 1'b0);
    do_reset();
    chk("midrst_y0", 32'(y0), 32'd0);
    chk("midrst_cnt", 32'(frame_cnt), 32'd0);
    chk("midrst_locked", 32'(locked), 32'd0);
    send_frame(4'd10, 4'd11, 4'd12, 4'd13, 0);
    idle(1);
    chk("after_rst_cnt", 32'(frame_cnt), 32'd1);
    for (int i = 0; i < 255; i++) begin
      send_frame(4'(i), 4'(i + 1), 4'(i + 5), 4'(i + 9), 0);
    end
    idle(2);
    chk("wrap_cnt", 32'(frame_cnt), 32'd0);
    chk("final_err", 32'(err_seen), 32'd2);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
